// File: rtl/mips16_muldiv.sv
// Iterative multiply/divide unit for the MIPS16 HI/LO registers.
// One shift-add or restoring-subtract step per clock, fixed WIDTH-cycle latency.
module mips16_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic               is_div_q, sa_q, sb_q, dbz_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               sa_in, sb_in, last;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, step;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign sa_in = op[0] & a[WIDTH-1];
  assign sb_in = op[0] & b[WIDTH-1];
  assign abs_a = sa_in ? -a : a;
  assign abs_b = sb_in ? -b : b;
  assign last  = (count_q == CW'(WIDTH - 1));

  // Multiply: work = {accumulator, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // Divide: work = {partial remainder, dividend bits / quotient bits}, shifted left each step.
  assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  always_comb begin
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end
    step = is_div_q ? div_next : mul_next;
  end

  always_comb begin
    res_hi = step[2*WIDTH-1:WIDTH];
    res_lo = step[WIDTH-1:0];
    if (is_div_q) begin
      if (sa_q ^ sb_q) res_lo = -step[WIDTH-1:0];
      if (sa_q)        res_hi = -step[2*WIDTH-1:WIDTH];
    end else if (sa_q ^ sb_q) begin
      {res_hi, res_lo} = -step;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dbz_q    <= 1'b0;
      opnd_q   <= '0;
      work_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            sa_q     <= sa_in;
            sb_q     <= sb_in;
            count_q  <= '0;
            dbz_q    <= op[1] && (b == '0);
            opnd_q   <= op[1] ? abs_b : abs_a;
            work_q   <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          end
        end
        S_RUN: begin
          work_q  <= step;
          count_q <= count_q + 1'b1;
          if (last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign ready       = (state_q == S_DONE);
  assign div_by_zero = (state_q == S_DONE) && dbz_q;

endmodule
